// File: rtl/count_cmd_seq.sv
// Command sequencer: queues (select, length) commands in a small FIFO and
// replays each one as a run of enable cycles to a downstream counter.
module count_cmd_seq #(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic                     In_Slt,
  input  logic [7:0]               In_Len,
  input  logic                     Hold,
  output logic                     Out_En,
  output logic                     Out_Slt,
  output logic                     Done,
  output logic [$clog2(DEPTH):0]   Fifo_Cnt,
  output logic [15:0]              Issued_Cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic {IDLE, RUN} state_t;

  // Queue entries are {select, length}.
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg = '0;
  logic [AW-1:0] rd_ptr_reg = '0;
  logic [AW:0]   count_reg  = '0;

  state_t        state_reg   = IDLE;
  logic [8:0]    rem_reg     = '0;
  logic          cur_slt_reg = 1'b0;
  logic          done_reg    = 1'b0;
  logic [15:0]   issued_reg  = '0;

  logic       push;
  logic       pop;
  logic       finishing;
  logic [8:0] head;
  logic [8:0] head_len;

  assign In_Ready   = (count_reg < CNT_FULL);
  assign push       = In_Valid && In_Ready;
  assign head       = mem[rd_ptr_reg];
  assign head_len   = (head[7:0] == 8'd0) ? 9'd256 : {1'b0, head[7:0]};
  assign finishing  = (state_reg == RUN) && !Hold && (rem_reg == 9'd1);
  // The next command is taken either from idle or back-to-back on the last
  // enable cycle of the current one, so Out_En has no gap between commands.
  assign pop        = (count_reg != '0) && ((state_reg == IDLE) || finishing);

  assign Out_En     = (state_reg == RUN) && !Hold;
  assign Out_Slt    = (state_reg == RUN) && cur_slt_reg;
  assign Done       = done_reg;
  assign Fifo_Cnt   = count_reg;
  assign Issued_Cnt = issued_reg;

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {In_Slt, In_Len};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      state_reg   <= IDLE;
      rem_reg     <= '0;
      cur_slt_reg <= 1'b0;
      done_reg    <= 1'b0;
      issued_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase

      if (Out_En) begin
        issued_reg <= issued_reg + 16'd1;
      end
      done_reg <= finishing;

      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg   <= RUN;
            rem_reg     <= head_len;
            cur_slt_reg <= head[8];
          end
        end
        RUN: begin
          if (!Hold) begin
            if (rem_reg == 9'd1) begin
              if (pop) begin
                rem_reg     <= head_len;
                cur_slt_reg <= head[8];
              end else begin
                state_reg   <= IDLE;
                rem_reg     <= '0;
                cur_slt_reg <= 1'b0;
              end
            end else begin
              rem_reg <= rem_reg - 9'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_cmd_seq.sv
// Directed bench for count_cmd_seq: each step drives inputs, advances the
// clock and compares outputs against hand-computed values.
module tb_count_cmd_seq;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Reset;
  logic        In_Valid;
  logic        In_Ready;
  logic        In_Slt;
  logic [7:0]  In_Len;
  logic        Hold;
  logic        Out_En;
  logic        Out_Slt;
  logic        Done;
  logic [2:0]  Fifo_Cnt;
  logic [15:0] Issued_Cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int en_cnt;
  int done_cnt;
  int held_cnt;

  count_cmd_seq #(.DEPTH(DEPTH)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .In_Slt     (In_Slt),
    .In_Len     (In_Len),
    .Hold       (Hold),
    .Out_En     (Out_En),
    .Out_Slt    (Out_Slt),
    .Done       (Done),
    .Fifo_Cnt   (Fifo_Cnt),
    .Issued_Cnt (Issued_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    Reset = 1'b1; In_Valid = 1'b0; In_Slt = 1'b0; In_Len = 8'd0; Hold = 1'b0;
    #1;
    check("init_fifo_cnt", 32'(Fifo_Cnt), 0);
    check("init_issued", 32'(Issued_Cnt), 0);
    check("init_out_en", 32'(Out_En), 0);

    // Two reset cycles
    tick(); tick();
    check("rst_out_en", 32'(Out_En), 0);
    check("rst_out_slt", 32'(Out_Slt), 0);
    check("rst_fifo_cnt", 32'(Fifo_Cnt), 0);
    check("rst_in_ready", 32'(In_Ready), 1);
    check("rst_done", 32'(Done), 0);
    check("rst_issued", 32'(Issued_Cnt), 0);
    Reset = 1'b0;

    // Single command Slt=0 Len=3
    In_Valid = 1'b1; In_Slt = 1'b0; In_Len = 8'd3;
    tick();
    In_Valid = 1'b0;
    check("single_queued", 32'(Fifo_Cnt), 1);
    check("single_no_en_yet", 32'(Out_En), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_en", 32'(Out_En), 1);
      check("single_slt", 32'(Out_Slt), 0);
      check("single_no_done", 32'(Done), 0);
    end
    tick();
    check("single_en_off", 32'(Out_En), 0);
    check("single_done", 32'(Done), 1);
    check("single_issued", 32'(Issued_Cnt), 3);
    tick();
    check("single_done_pulse", 32'(Done), 0);

    // Back-to-back commands Slt=1 Len=2 then Slt=0 Len=1
    In_Valid = 1'b1; In_Slt = 1'b1; In_Len = 8'd2;
    tick();
    In_Slt = 1'b0; In_Len = 8'd1;
    tick();
    In_Valid = 1'b0;
    check("b2b_en0", 32'(Out_En), 1);
    check("b2b_slt0", 32'(Out_Slt), 1);
    check("b2b_done0", 32'(Done), 0);
    tick();
    check("b2b_en1", 32'(Out_En), 1);
    check("b2b_slt1", 32'(Out_Slt), 1);
    tick();
    check("b2b_en2", 32'(Out_En), 1);
    check("b2b_slt2", 32'(Out_Slt), 0);
    check("b2b_done2", 32'(Done), 1);
    tick();
    check("b2b_en_off", 32'(Out_En), 0);
    check("b2b_done3", 32'(Done), 1);
    check("b2b_issued", 32'(Issued_Cnt), 6);
    tick();
    check("b2b_done_end", 32'(Done), 0);

    // Fill the FIFO while the running command is held
    In_Valid = 1'b1; In_Slt = 1'b0; In_Len = 8'd5; Hold = 1'b1;
    tick();
    In_Valid = 1'b0;
    tick();
    check("hold_en", 32'(Out_En), 0);
    check("hold_fifo_empty", 32'(Fifo_Cnt), 0);
    for (int i = 0; i <= DEPTH; i++) begin
      In_Valid = 1'b1;
      In_Slt = i[0];
      In_Len = (i == DEPTH) ? 8'd7 : 8'(i + 1);
      check("fill_ready", 32'(In_Ready), (i < DEPTH) ? 1 : 0);
      tick();
      check("fill_cnt", 32'(Fifo_Cnt), (i < DEPTH) ? i + 1 : DEPTH);
      check("fill_en", 32'(Out_En), 0);
    end
    In_Valid = 1'b0;
    check("fill_issued", 32'(Issued_Cnt), 6);
    Hold = 1'b0;
    #1;
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      en_cnt += int'(Out_En);
      done_cnt += int'(Done);
      tick();
    end
    check("drain_en_cycles", en_cnt, 15);
    check("drain_done_pulses", done_cnt, 5);
    check("drain_issued", 32'(Issued_Cnt), 21);
    check("drain_fifo", 32'(Fifo_Cnt), 0);

    // Len=0 means 256 enable cycles
    In_Valid = 1'b1; In_Slt = 1'b1; In_Len = 8'd0;
    tick();
    In_Valid = 1'b0;
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      en_cnt += int'(Out_En && Out_Slt);
      done_cnt += int'(Done);
      tick();
    end
    check("len0_en_cycles", en_cnt, 256);
    check("len0_done", done_cnt, 1);
    check("len0_issued", 32'(Issued_Cnt), 277);

    // Hold for 5 cycles in the middle of a Len=10 command
    In_Valid = 1'b1; In_Slt = 1'b0; In_Len = 8'd10;
    tick();
    In_Valid = 1'b0;
    en_cnt = 0; done_cnt = 0; held_cnt = 0;
    tick();
    en_cnt += int'(Out_En);
    tick();
    Hold = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      held_cnt += int'(Out_En);
      tick();
    end
    Hold = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      en_cnt += int'(Out_En);
      done_cnt += int'(Done);
      tick();
    end
    check("midhold_held_en", held_cnt, 0);
    check("midhold_en_total", en_cnt, 10);
    check("midhold_done", done_cnt, 1);
    check("midhold_issued", 32'(Issued_Cnt), 287);

    // Reset in the 2nd cycle of a Len=10 command with 2 queued
    In_Valid = 1'b1; In_Slt = 1'b1; In_Len = 8'd10;
    tick();
    In_Slt = 1'b0; In_Len = 8'd4;
    tick();
    In_Len = 8'd5;
    tick();
    In_Valid = 1'b0;
    check("pre_rst_en", 32'(Out_En), 1);
    check("pre_rst_fifo", 32'(Fifo_Cnt), 2);
    Reset = 1'b1;
    tick();
    check("midrst_en", 32'(Out_En), 0);
    check("midrst_slt", 32'(Out_Slt), 0);
    check("midrst_fifo", 32'(Fifo_Cnt), 0);
    check("midrst_done", 32'(Done), 0);
    check("midrst_issued", 32'(Issued_Cnt), 0);
    check("midrst_ready", 32'(In_Ready), 1);
    Reset = 1'b0;
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      en_cnt += int'(Out_En);
      done_cnt += int'(Done);
    end
    check("postrst_en", en_cnt, 0);
    check("postrst_done", done_cnt, 0);
    check("postrst_issued", 32'(Issued_Cnt), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
